// File: rtl/uart_disp_ctrl_pkg.sv
// uart_disp_ctrl_pkg
//   Shared constants and types for the UART command-frame display controller.
//   Frame layout: SYNC, CMD, D0, D1, CHK   (CHK = CMD ^ D0 ^ D1)
package uart_disp_ctrl_pkg;

   localparam logic [7:0] SYNC_BYTE     = 8'hA5;
   localparam logic [7:0] CMD_SET       = 8'h01;
   localparam logic [7:0] CMD_BLANK     = 8'h02;
   localparam logic [7:0] CMD_ADD       = 8'h03;
   localparam logic [7:0] CMD_CLR_STATS = 8'h04;
   localparam int         FRAME_LEN     = 5;

   // Each state names the byte that is expected next.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_D0,
      ST_D1,
      ST_CHK
   } state_t;

endpackage

// File: rtl/uart_disp_ctrl_timer.sv
// frame_timer
//   Inter-byte timeout counter.
//   Ports:
//     clk, rst  clock / asynchronous active-high reset
//     clr       synchronous clear (wins over en)
//     en        count enable (frame in progress)
//     expire    high while enabled and the count sits at TIMEOUT_CYCLES-1
module frame_timer #(
   parameter int TIMEOUT_CYCLES = 50_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int              W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [W-1:0]    LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       cnt <= '0;
      else if (clr)  cnt <= '0;
      else if (en)   cnt <= cnt + 1'b1;
   end

   // The owner clears the counter on expiry, so it never passes LAST.
   assign expire = en && (cnt == LAST);

endmodule

// File: rtl/uart_disp_ctrl.sv
// uart_disp_ctrl
//   Parses 5-byte command frames (A5, CMD, D0, D1, CHK) from the UART
//   receiver and updates the 16-bit hex display value / blank flag.
//   Bad checksum, unknown command or inter-byte timeout drop the frame
//   with a one-cycle o_err pulse.
//   Optional: define UART_DISP_CTRL_STATS_EN to add o_err_cnt (saturating
//   error counter, cleared by command 8'h04).
//   Ports:
//     clk, rst    clock / asynchronous active-high reset
//     i_data      received byte, qualified by i_vld
//     i_vld       one-cycle strobe per byte
//     o_value     display value
//     o_blank     display blank flag
//     o_upd       pulse: value/blank updated by a command
//     o_err       pulse: frame dropped
//     o_busy      frame in progress
//     o_err_cnt   (STATS_EN only) error count
module uart_disp_ctrl
   import uart_disp_ctrl_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 50_000,
   parameter logic [15:0] RESET_VALUE    = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  i_data,
   input  logic        i_vld,
   output logic [15:0] o_value,
   output logic        o_blank,
   output logic        o_upd,
   output logic        o_err,
`ifdef UART_DISP_CTRL_STATS_EN
   output logic [7:0]  o_err_cnt,
`endif
   output logic        o_busy
);

   state_t      state, state_nxt;
   logic [7:0]  cmd_q, d0_q, d1_q;
   logic [15:0] value_nxt;
   logic        blank_nxt, upd_nxt, err_nxt;
   logic        tmo_expire, tmo_hit;
   logic        stats_clr;

   assign o_busy  = (state != ST_IDLE);
   // A byte arriving on the expiry cycle is accepted instead of timing out.
   assign tmo_hit = tmo_expire && !i_vld;

   frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (i_vld || !o_busy || tmo_hit),
      .en     (o_busy),
      .expire (tmo_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      value_nxt = o_value;
      blank_nxt = o_blank;
      upd_nxt   = 1'b0;
      err_nxt   = 1'b0;
      stats_clr = 1'b0;
      if (i_vld) begin
         case (state)
            ST_IDLE: if (i_data == SYNC_BYTE) state_nxt = ST_CMD;
            ST_CMD:  state_nxt = ST_D0;
            ST_D0:   state_nxt = ST_D1;
            ST_D1:   state_nxt = ST_CHK;
            ST_CHK: begin
               state_nxt = ST_IDLE;
               // Checksum gates decode so a bad frame yields exactly one error.
               if (i_data != (cmd_q ^ d0_q ^ d1_q)) begin
                  err_nxt = 1'b1;
               end else begin
                  case (cmd_q)
                     CMD_SET: begin
                        value_nxt = {d0_q, d1_q};
                        upd_nxt   = 1'b1;
                     end
                     CMD_BLANK: begin
                        blank_nxt = d0_q[0];
                        upd_nxt   = 1'b1;
                     end
                     CMD_ADD: begin
                        value_nxt = o_value + {d0_q, d1_q};
                        upd_nxt   = 1'b1;
                     end
`ifdef UART_DISP_CTRL_STATS_EN
                     CMD_CLR_STATS: begin
                        stats_clr = 1'b1;
                        upd_nxt   = 1'b1;
                     end
`endif
                     default: err_nxt = 1'b1;
                  endcase
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end else if (tmo_hit) begin
         state_nxt = ST_IDLE;
         err_nxt   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_q   <= '0;
         d0_q    <= '0;
         d1_q    <= '0;
         o_value <= RESET_VALUE;
         o_blank <= 1'b0;
         o_upd   <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         if (i_vld && state == ST_CMD) cmd_q <= i_data;
         if (i_vld && state == ST_D0)  d0_q  <= i_data;
         if (i_vld && state == ST_D1)  d1_q  <= i_data;
         o_value <= value_nxt;
         o_blank <= blank_nxt;
         o_upd   <= upd_nxt;
         o_err   <= err_nxt;
      end
   end

`ifdef UART_DISP_CTRL_STATS_EN
   // Counts in step with o_err so the new count is visible with the pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              o_err_cnt <= '0;
      else if (stats_clr)                   o_err_cnt <= '0;
      else if (err_nxt && o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'd1;
   end
`else
   logic unused_stats;
   assign unused_stats = stats_clr;
`endif

endmodule

// File: tb/tb_uart_disp_ctrl.sv
// tb_uart_disp_ctrl
//   Directed frames; expected update/error events are queued by the
//   stimulus and consumed by a monitor on every o_upd/o_err pulse.
module tb_uart_disp_ctrl;

   localparam int TMO = 16;

   typedef struct {
      bit          is_err;
      logic [15:0] value;
      logic        blank;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  i_data = '0;
   logic        i_vld = 1'b0;
   logic [15:0] o_value;
   logic        o_blank, o_upd, o_err, o_busy;
`ifdef UART_DISP_CTRL_STATS_EN
   logic [7:0]  o_err_cnt;
`endif

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   uart_disp_ctrl #(.TIMEOUT_CYCLES(TMO), .RESET_VALUE(16'h0000)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_data  (i_data),
      .i_vld   (i_vld),
      .o_value (o_value),
      .o_blank (o_blank),
      .o_upd   (o_upd),
      .o_err   (o_err),
`ifdef UART_DISP_CTRL_STATS_EN
      .o_err_cnt (o_err_cnt),
`endif
      .o_busy  (o_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_upd(input logic [15:0] v, input logic b);
      exp_t e;
      e.is_err = 1'b0; e.value = v; e.blank = b;
      exp_q.push_back(e);
   endtask

   task automatic push_err(input logic [15:0] v, input logic b);
      exp_t e;
      e.is_err = 1'b1; e.value = v; e.blank = b;
      exp_q.push_back(e);
   endtask

   // Byte is sampled on the posedge after the negedge it is driven on;
   // the task returns on the following negedge.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      i_data = b;
      i_vld  = 1'b1;
      @(negedge clk);
      i_vld  = 1'b0;
   endtask

   // After the CHK byte, the result pulse must already be present.
   task automatic send_frame(input logic [7:0] c, input logic [7:0] d0,
                             input logic [7:0] d1, input logic [7:0] k);
      send_byte(8'hA5); send_byte(c); send_byte(d0); send_byte(d1); send_byte(k);
      check("latency", {31'd0, (o_upd | o_err)}, 32'd1);
      check("busy_after_frame", {31'd0, o_busy}, 32'd0);
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      if (o_upd || o_err) begin
         check("upd_err_exclusive", {31'd0, (o_upd & o_err)}, 32'd0);
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_pulse: upd=%0b err=%0b value=%0h, none expected",
                     o_upd, o_err, o_value);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("kind_is_err", {31'd0, o_err}, {31'd0, e.is_err});
            check("value", {16'd0, o_value}, {16'd0, e.value});
            check("blank", {31'd0, o_blank}, {31'd0, e.blank});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, stimulus incomplete");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_value", {16'd0, o_value}, 32'h0);
      check("rst_blank", {31'd0, o_blank}, 32'd0);
      check("rst_upd",   {31'd0, o_upd},   32'd0);
      check("rst_err",   {31'd0, o_err},   32'd0);
      check("rst_busy",  {31'd0, o_busy},  32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic SET (01^12^34 = 27).
      push_upd(16'h1234, 1'b0);
      send_frame(8'h01, 8'h12, 8'h34, 8'h27);

      // Leading junk ignored in IDLE.
      send_byte(8'h00); send_byte(8'hFF);
      check("junk_not_busy", {31'd0, o_busy}, 32'd0);
      push_upd(16'hABCD, 1'b0);
      send_frame(8'h01, 8'hAB, 8'hCD, 8'h67);

      // Bad checksum, then unknown command.
      push_err(16'hABCD, 1'b0);
      send_frame(8'h01, 8'h12, 8'h34, 8'h00);
      push_err(16'hABCD, 1'b0);
      send_frame(8'h07, 8'h00, 8'h00, 8'h07);

      // A5 inside a frame is data (01^A5^00 = A4).
      push_upd(16'hA500, 1'b0);
      send_frame(8'h01, 8'hA5, 8'h00, 8'hA4);

      // Wraparound add, then blank.
      push_upd(16'hFFFF, 1'b0);
      send_frame(8'h01, 8'hFF, 8'hFF, 8'h01);
      push_upd(16'h0001, 1'b0);
      send_frame(8'h03, 8'h00, 8'h02, 8'h01);
      push_upd(16'h0001, 1'b1);
      send_frame(8'h02, 8'h01, 8'h00, 8'h03);
      // Same value again still pulses o_upd.
      push_upd(16'h0001, 1'b1);
      send_frame(8'h01, 8'h00, 8'h01, 8'h00);

      // Timeout: CMD byte sampled at edge E; expiry edge is E+TMO.
      send_byte(8'hA5); send_byte(8'h01);
      repeat (TMO - 1) @(negedge clk);
      check("tmo_busy_before", {31'd0, o_busy}, 32'd1);
      check("tmo_err_before",  {31'd0, o_err},  32'd0);
      push_err(16'h0001, 1'b1);
      @(negedge clk);
      check("tmo_err_pulse", {31'd0, o_err},  32'd1);
      check("tmo_busy_drop", {31'd0, o_busy}, 32'd0);
      @(negedge clk);

      // Byte lands exactly on the expiry cycle: accepted, frame completes.
      send_byte(8'hA5); send_byte(8'h01);
      repeat (TMO - 2) @(negedge clk);
      send_byte(8'h12);
      check("tmo_byte_wins_busy", {31'd0, o_busy}, 32'd1);
      send_byte(8'h34);
      push_upd(16'h1234, 1'b1);
      send_byte(8'h27);
      check("tmo_frame_done", {31'd0, o_upd}, 32'd1);

      // Reset mid-frame.
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check("midrst_value", {16'd0, o_value}, 32'h0);
      check("midrst_blank", {31'd0, o_blank}, 32'd0);
      check("midrst_busy",  {31'd0, o_busy},  32'd0);
      check("midrst_err",   {31'd0, o_err},   32'd0);
      rst = 1'b0;
      @(negedge clk);
      push_upd(16'hABCD, 1'b0);
      send_frame(8'h01, 8'hAB, 8'hCD, 8'h67);

`ifdef UART_DISP_CTRL_STATS_EN
      check("stats_after_rst", {24'd0, o_err_cnt}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         push_err(16'hABCD, 1'b0);
         send_frame(8'h01, 8'h00, 8'h00, 8'h55);
      end
      check("stats_three", {24'd0, o_err_cnt}, 32'd3);
      push_upd(16'hABCD, 1'b0);
      send_frame(8'h04, 8'h00, 8'h00, 8'h04);
      check("stats_cleared", {24'd0, o_err_cnt}, 32'd0);
`else
      push_err(16'hABCD, 1'b0);
      send_frame(8'h04, 8'h00, 8'h00, 8'h04);
`endif

      repeat (4) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
